// File: rtl/busca_instrucao.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | busca_instrucao : instruction fetch with PC, ROM read, prefetch FIFO,    |
// |                   valid/ready output, jump redirect and HALT draining.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module busca_instrucao #(
   parameter int                ADDR_W    = 4,
   parameter int                DATA_W    = 4,
   parameter int                FUNC_W    = 4,
   parameter int                PROG_LEN  = 16,
   parameter int                DEPTH     = 2,
   parameter logic [FUNC_W-1:0] HALT_FUNC = 4'hF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_val,
   input  logic [FUNC_W-1:0] mem_func,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_val,
   output logic [FUNC_W-1:0] instr_func,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              halted
);

   localparam int c_CNT_W   = $clog2(DEPTH + 1);
   localparam int c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_ENTRY_W = FUNC_W + DATA_W + ADDR_W;

   localparam logic [ADDR_W-1:0]  c_PC_LAST  = ADDR_W'(PROG_LEN - 1);
   localparam logic [ADDR_W:0]    c_PROG_LEN = (ADDR_W + 1)'(PROG_LEN);
   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
   localparam logic [c_CNT_W:0]   c_DEPTH    = (c_CNT_W + 1)'(DEPTH);

   localparam logic [1:0] c_RUN    = 2'd0;
   localparam logic [1:0] c_DRAIN  = 2'd1;
   localparam logic [1:0] c_HALTED = 2'd2;

   logic [ADDR_W-1:0]    r_pc;
   logic [ADDR_W-1:0]    r_inflight_addr;
   logic                 r_inflight;
   logic [1:0]           r_state;
   logic [c_ENTRY_W-1:0] r_fifo [DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_CNT_W-1:0]   r_count;

   logic                 w_valid;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_push_halt;
   logic                 w_pop_halt;
   logic                 w_issue;
   logic [c_CNT_W:0]     w_occupancy;
   logic [c_ENTRY_W-1:0] w_head;
   logic [FUNC_W-1:0]    w_head_func;
   logic [DATA_W-1:0]    w_head_val;
   logic [ADDR_W-1:0]    w_head_pc;
   logic [ADDR_W-1:0]    w_pc_next;
   logic [ADDR_W:0]      w_jump_mod;
   logic [ADDR_W-1:0]    w_jump_pc;

   assign w_valid     = (r_count != '0);
   assign w_pop       = w_valid & instr_ready;

   // Returning data is only accepted in RUN; in DRAIN it is the stale word behind HALT.
   assign w_push      = r_inflight & (r_state == c_RUN) & ~jump_en;
   assign w_push_halt = w_push & (mem_func == HALT_FUNC);

   assign w_head      = r_fifo[r_rd_ptr];
   assign w_head_func = w_head[c_ENTRY_W-1 -: FUNC_W];
   assign w_head_val  = w_head[ADDR_W +: DATA_W];
   assign w_head_pc   = w_head[ADDR_W-1:0];
   assign w_pop_halt  = w_pop & (r_state == c_DRAIN) & (w_head_func == HALT_FUNC);

   // Counting the in-flight read reserves its slot before the data arrives.
   assign w_occupancy = {1'b0, r_count} + (c_CNT_W + 1)'(r_inflight)
                        - (c_CNT_W + 1)'(w_pop);
   assign w_issue     = rst_n & (r_state == c_RUN) & ~jump_en & (w_occupancy < c_DEPTH);

   assign w_pc_next   = (r_pc == c_PC_LAST) ? '0 : r_pc + ADDR_W'(1);
   assign w_jump_mod  = {1'b0, jump_addr} % c_PROG_LEN;
   assign w_jump_pc   = w_jump_mod[ADDR_W-1:0];

   assign mem_rd_en   = w_issue;
   assign mem_addr    = r_pc;
   assign instr_valid = w_valid;
   assign instr_val   = w_valid ? w_head_val  : '0;
   assign instr_func  = w_valid ? w_head_func : '0;
   assign instr_pc    = w_valid ? w_head_pc   : '0;
   assign halted      = (r_state == c_HALTED);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= {mem_func, mem_val, r_inflight_addr};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc            <= '0;
         r_inflight_addr <= '0;
         r_inflight      <= 1'b0;
         r_state         <= c_RUN;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_addr <= r_pc;
            r_pc            <= w_pc_next;
         end

         if (jump_en) begin
            r_pc     <= w_jump_pc;
            r_state  <= c_RUN;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

            case (r_state)
               c_RUN:    if (w_push_halt) r_state <= c_DRAIN;
               c_DRAIN:  if (w_pop_halt)  r_state <= c_HALTED;
               c_HALTED: r_state <= c_HALTED;
               default:  r_state <= c_RUN;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
